// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table checker.
//   N_INPUTS   : number of stimulus lines driven to the device under test
//   N_PATTERNS : number of input combinations swept (2**N_INPUTS)
//   state_e    : sweep controller states
package tt_pkg;

  localparam int N_INPUTS   = 4;
  localparam int N_PATTERNS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/tt_hold_timer.sv
// Hold counter for the truth-table checker. Counts cycles a pattern has
// been driven; tc flags the last hold cycle (count == HOLD_CYCLES-1) and
// the counter wraps to zero after it.
//   clk   : clock
//   rst   : synchronous active-high reset
//   clear : forces the count to zero (has priority over en)
//   en    : advance the count this cycle
//   tc    : terminal-count flag
module tt_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [7:0] cnt_q;

  assign tc = (cnt_q == 8'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= 8'd0;
    end else if (en) begin
      cnt_q <= tc ? 8'd0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/truth_table_checker.sv
// Truth-table checker: sweeps all 16 input patterns into an external
// combinational device, holds each pattern HOLD_CYCLES cycles, samples f
// on the last hold cycle and compares it against a latched expected table.
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : begin a sweep / cancel a sweep in progress
//   expected          : expected truth table (bit i = f for pattern i)
//   a, b, c, d        : registered stimulus, {a,b,c,d} = pattern index
//   f                 : response from the device under test
//   busy, done        : sweep in progress / one-cycle completion pulse
//   pass              : last completed sweep had no mismatches
//   captured          : sampled truth table
//   mismatch_count    : number of mismatching patterns
//   first_fail(_valid): lowest mismatching pattern and its qualifier
module truth_table_checker
  import tt_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [N_PATTERNS-1:0] expected,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  input  logic                  f,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_PATTERNS-1:0] captured,
  output logic [4:0]            mismatch_count,
  output logic [N_INPUTS-1:0]   first_fail,
  output logic                  first_fail_valid
);

  localparam logic [N_INPUTS-1:0] LAST_IDX = N_INPUTS'(N_PATTERNS - 1);

  state_e                state_q, state_d;
  logic [N_INPUTS-1:0]   index_q;
  logic [N_INPUTS-1:0]   pattern_q;
  logic [N_PATTERNS-1:0] exp_q;
  logic                  tc;
  logic                  accept, sample, finish;

  // Hold timer runs only while driving; abort clears it with the sweep.
  tt_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q != ST_DRIVE || abort),
    .en   (state_q == ST_DRIVE),
    .tc   (tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort wins over start and over the final sample.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && !abort) state_d = ST_DRIVE;
      ST_DRIVE: begin
        if (abort)                        state_d = ST_IDLE;
        else if (tc && index_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control strobes
  always_comb begin
    busy   = (state_q != ST_IDLE);
    accept = (state_q == ST_IDLE)  && start && !abort;
    sample = (state_q == ST_DRIVE) && tc && !abort;
    finish = (state_q == ST_DONE);
  end

  // Sweep datapath and result registers. done and pass are registered on
  // leaving DONE, so the pass verdict already includes the final sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_q          <= '0;
      pattern_q        <= '0;
      exp_q            <= '0;
      captured         <= '0;
      mismatch_count   <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
      done             <= 1'b0;
    end else begin
      done <= finish;
      if (finish) pass <= (mismatch_count == 5'd0);

      if (accept) begin
        exp_q            <= expected;
        captured         <= '0;
        mismatch_count   <= '0;
        first_fail       <= '0;
        first_fail_valid <= 1'b0;
        index_q          <= '0;
      end else if (sample) begin
        captured[index_q] <= f;
        if (f != exp_q[index_q]) begin
          mismatch_count <= mismatch_count + 5'd1;
          if (!first_fail_valid) begin
            first_fail       <= index_q;
            first_fail_valid <= 1'b1;
          end
        end
        if (index_q != LAST_IDX) index_q <= index_q + 1'b1;
      end

      // Stimulus presents the next pattern as soon as the current one is sampled.
      if (accept)                             pattern_q <= '0;
      else if (sample && index_q != LAST_IDX) pattern_q <= index_q + 1'b1;
      else if (state_d != ST_DRIVE)           pattern_q <= '0;
    end
  end

  assign {a, b, c, d} = pattern_q;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] expected;
  logic        a, b, c, d, f;
  logic        busy, done, pass, first_fail_valid;
  logic [15:0] captured;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail;
  logic [15:0] dut_tt;

  truth_table_checker #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
    .a(a), .b(b), .c(c), .d(d), .f(f),
    .busy(busy), .done(done), .pass(pass), .captured(captured),
    .mismatch_count(mismatch_count), .first_fail(first_fail),
    .first_fail_valid(first_fail_valid)
  );

  // Device under test emulated as an arbitrary 16-entry truth table.
  assign f = dut_tt[{a, b, c, d}];

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cap;
    int          mc;
    int          ff;
    bit          ffv;
    bit          pass;
    int          done_edge;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  bit   prev_pass = 1'b0;
  int   act_start = -1;
  int   act_end = -1;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: result after the first k patterns have been sampled.
  function automatic exp_t model(input logic [15:0] tt, input logic [15:0] ex,
                                 input int k, input bit full, input int de);
    exp_t m;
    m.cap = '0; m.mc = 0; m.ff = 0; m.ffv = 1'b0;
    for (int i = 0; i < k; i++) begin
      m.cap[i] = tt[i];
      if (tt[i] != ex[i]) begin
        if (!m.ffv) begin m.ff = i; m.ffv = 1'b1; end
        m.mc++;
      end
    end
    m.pass = full ? (m.mc == 0) : prev_pass;
    m.done_edge = de;
    return m;
  endfunction

  // Monitor: stimulus pattern during a sweep, idle pattern, and done results.
  always @(negedge clk) begin
    if (act_start >= 0 && edge_cnt >= act_start && edge_cnt < act_end) begin
      chk("pattern", int'({a, b, c, d}), (edge_cnt - act_start) / H);
      chk("busy_drive", int'(busy), 1);
    end
    if (!busy && !rst) chk("idle_pattern", int'({a, b, c, d}), 0);
    if (done) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (edge %0d)", edge_cnt);
      end else begin
        e = q.pop_front();
        chk("done_edge", edge_cnt, e.done_edge);
        chk("captured", int'(captured), int'(e.cap));
        chk("mismatch_count", int'(mismatch_count), e.mc);
        chk("first_fail", int'(first_fail), e.ff);
        chk("first_fail_valid", int'(first_fail_valid), int'(e.ffv));
        chk("pass", int'(pass), int'(e.pass));
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic check_results(input string tag, input exp_t m);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_captured"}, int'(captured), int'(m.cap));
    chk({tag, "_mismatch_count"}, int'(mismatch_count), m.mc);
    chk({tag, "_first_fail"}, int'(first_fail), m.ff);
    chk({tag, "_first_fail_valid"}, int'(first_fail_valid), int'(m.ffv));
    chk({tag, "_pass"}, int'(pass), int'(m.pass));
  endtask

  task automatic check_zero(input string tag);
    exp_t z;
    z.cap = '0; z.mc = 0; z.ff = 0; z.ffv = 1'b0; z.pass = 1'b0; z.done_edge = 0;
    check_results(tag, z);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_abcd"}, int'({a, b, c, d}), 0);
  endtask

  task automatic full_sweep(input logic [15:0] tt, input logic [15:0] ex, input bit junk);
    int s;
    exp_t m;
    dut_tt = tt; expected = ex;
    s = edge_cnt + 1;
    m = model(tt, ex, 16, 1'b1, s + 16 * H + 1);
    q.push_back(m);
    act_start = s; act_end = s + 16 * H;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16 * H + 10 && q.size() != 0; i++) begin
      if (junk && i < 16 * H - 2) begin
        start = ($urandom_range(0, 5) == 0);
        expected = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done at edge %0d", m.done_edge);
      q.delete();
    end
    prev_pass = m.pass;
  endtask

  task automatic abort_sweep(input logic [15:0] tt, input logic [15:0] ex, input int dl);
    int s;
    exp_t m;
    dut_tt = tt; expected = ex;
    s = edge_cnt + 1;
    act_start = s; act_end = s + dl;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (dl - 1) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m = model(tt, ex, (dl - 1) / H, 1'b0, 0);
    check_results("abort", m);
    repeat (16 * H + 4) tick();
    check_results("abort_hold", m);
  endtask

  initial begin
    exp_t m;
    logic [15:0] tt, ex;
    rst = 1'b1; start = 1'b0; abort = 1'b0; expected = '0; dut_tt = '0;
    tick(); tick(); tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // f = (a&b)|(c&d) has truth table 16'hF888.
    full_sweep(16'hF888, 16'hF888, 1'b1);
    full_sweep(16'hF888, 16'hF889, 1'b0);
    full_sweep(16'hF888, 16'h0000, 1'b0);
    // Abort sampled 20 edges after start: patterns 0..3 captured.
    abort_sweep(16'hF888, 16'hF888, 20);
    chk("abort_captured_low", int'(captured), 16'h0008);

    // start with abort in IDLE: nothing changes.
    m = model(16'hF888, 16'hF888, 4, 1'b0, 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick(); tick();
    check_results("start_abort", m);

    // Completed sweep, then a second run with a stray start and a reset.
    full_sweep(16'hF888, 16'hF888, 1'b0);
    dut_tt = 16'hF888; expected = 16'hF888;
    act_start = edge_cnt + 1; act_end = edge_cnt + 31;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j < 30; j++) begin
      start = (j == 10);
      tick();
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("mid_reset");
    prev_pass = 1'b0;
    repeat (16 * H + 4) tick();
    check_zero("post_reset");

    // Randomized sweeps and aborts.
    for (int n = 0; n < 10; n++) begin
      tt = 16'($urandom);
      ex = ($urandom_range(0, 2) == 0) ? tt : tt ^ 16'($urandom);
      if ($urandom_range(0, 3) == 0) abort_sweep(tt, ex, int'($urandom_range(1, 16 * H)));
      else                           full_sweep(tt, ex, 1'b1);
    end

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
